// File: rtl/uart_rx_byte.sv
// 16x oversampling UART receiver: 8 data bits, optional odd/even parity, one stop bit.
// Each good byte appears on rx_data with a rising edge on rdsig; framing/parity errors are flagged per byte.
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rdsig,
  output logic       frame_error,
  output logic       parity_error
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state_q, state_d;
  logic               rx_meta, rx_s, rx_s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sub_q, sub_d;
  logic [2:0]         idx_q, idx_d;
  logic [1:0]         smp_q, smp_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               perr_q, perr_d;
  logic [7:0]         rx_data_d;
  logic               rdsig_d, fe_d, pe_d;

  logic tick, resolve, bit_end, bit_v, start_edge;

  assign tick       = (cnt_q == DIV_LAST);
  assign resolve    = tick && (sub_q == 4'd8);
  assign bit_end    = tick && (sub_q == 4'd15);
  assign start_edge = rx_s_d && !rx_s;
  // 2-of-3 vote over the samples taken as sub advances to 7, 8 and 9
  assign bit_v      = (smp_q[0] & smp_q[1]) | (rx_s & (smp_q[0] | smp_q[1]));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    sub_d     = sub_q;
    idx_d     = idx_q;
    smp_d     = smp_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    rx_data_d = rx_data;
    rdsig_d   = rdsig;
    fe_d      = frame_error;
    pe_d      = parity_error;

    if (state_q != S_IDLE && tick) begin
      sub_d = sub_q + 4'd1;
      if (sub_q == 4'd6) smp_d[0] = rx_s;
      if (sub_q == 4'd7) smp_d[1] = rx_s;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_START;
          rdsig_d = 1'b0;
          cnt_d   = '0;
          sub_d   = '0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (resolve && bit_v) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (resolve) shreg_d = {bit_v, shreg_q[7:1]};
        if (bit_end) begin
          if (idx_q == 3'd7) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (resolve) perr_d = (PARITY == 1) ? ~(^{shreg_q, bit_v}) : (^{shreg_q, bit_v});
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (resolve) begin
          state_d = S_IDLE;
          if (!bit_v) begin
            fe_d = 1'b1;
          end else if (perr_q) begin
            pe_d = 1'b1;
            fe_d = 1'b0;
          end else begin
            rx_data_d = shreg_q;
            rdsig_d   = 1'b1;
            fe_d      = 1'b0;
            pe_d      = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchronizer, FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_s_d       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sub_q        <= '0;
      idx_q        <= '0;
      smp_q        <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      rx_data      <= 8'h00;
      rdsig        <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      rx_meta      <= rx;
      rx_s         <= rx_meta;
      rx_s_d       <= rx_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
      idx_q        <= idx_d;
      smp_q        <= smp_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      rx_data      <= rx_data_d;
      rdsig        <= rdsig_d;
      frame_error  <= fe_d;
      parity_error <= pe_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: a no-parity and an even-parity receiver fed from one bit-level line driver,
// checked every cycle against a frame-level model plus literal expectations at test milestones.
module tb_uart_rx_byte;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 625_000;      // 10 clk per tick, 160 clk per bit
  localparam int BIT    = 160;
  localparam int HALF   = BIT / 2;
  localparam int G      = 20;                      // settle window around each output change
  localparam int LAT_LO = 1504;                    // 9.4 bit times
  localparam int LAT_HI = 1536;                    // 9.6 bit times

  logic clk = 1'b0;
  logic rst_n;
  logic rx_line;
  int   sel;
  logic rx_none, rx_even;
  logic [7:0] dq [2];
  logic rdq [2];
  logic feq [2];
  logic peq [2];

  logic [7:0] m_data [2];
  logic m_rd [2];
  logic m_fe [2];
  logic m_pe [2];
  int   m_rises [2]  = '{0, 0};
  int   rises [2]    = '{0, 0};
  int   rise_cyc [2] = '{0, 0};
  logic rd_prev [2];

  int cyc = 0;
  int g_lo = 0;
  int g_hi = -1;
  int t_start = 0;
  bit run = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [7:0] msg [13] = '{8'h50, 8'h30, 8'h35, 8'h30, 8'h30, 8'h31, 8'h30,
                           8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx_none = (sel == 0) ? rx_line : 1'b1;
  assign rx_even = (sel == 2) ? rx_line : 1'b1;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .PARITY(0)) dut_none (
    .clk(clk), .rst_n(rst_n), .rx(rx_none), .rx_data(dq[0]), .rdsig(rdq[0]),
    .frame_error(feq[0]), .parity_error(peq[0]));

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .PARITY(2)) dut_even (
    .clk(clk), .rst_n(rst_n), .rx(rx_even), .rx_data(dq[1]), .rdsig(rdq[1]),
    .frame_error(feq[1]), .parity_error(peq[1]));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    wait_clk(n);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_data[k] = 8'h00;
      m_rd[k]   = 1'b0;
      m_fe[k]   = 1'b0;
      m_pe[k]   = 1'b0;
    end
  endtask

  // Drive one frame on the line to receiver k and update the model at mid-stop
  task automatic send_frame(input int k, input logic [7:0] b, input logic pbit,
                            input logic stop, input bit rst_mid);
    logic bits [0:10];
    int n;
    n = (k == 1) ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9] = pbit;
    bits[n-1] = stop;
    sel = (k == 1) ? 2 : 0;
    for (int i = 0; i < n; i++) begin
      rx_line = bits[i];
      if (i == 0) begin
        t_start = cyc;
        g_lo = cyc;
        g_hi = cyc + G;
        m_rd[k] = 1'b0;
      end
      if (rst_mid && i == 5) begin
        wait_clk(HALF);
        g_lo = cyc;
        g_hi = cyc + G;
        rst_n = 1'b0;
        model_reset();
        wait_clk(1);
        rst_n = 1'b1;
        idle(12 * BIT);
        return;
      end
      if (i == n - 1) begin
        wait_clk(HALF - G);
        g_lo = cyc;
        g_hi = cyc + 2 * G;
        wait_clk(G);
        if (!stop) begin
          m_fe[k] = 1'b1;
        end else if (k == 1 && (($countones(b) + int'(pbit)) % 2 == 1)) begin
          m_pe[k] = 1'b1;
          m_fe[k] = 1'b0;
        end else begin
          m_data[k] = b;
          m_rd[k]   = 1'b1;
          m_fe[k]   = 1'b0;
          m_pe[k]   = 1'b0;
          m_rises[k]++;
        end
        wait_clk(G);
        wait_clk(HALF - G);
      end else begin
        wait_clk(BIT);
      end
    end
  endtask

  // Rise counter and per-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rdq[k] === 1'b1 && rd_prev[k] !== 1'b1) begin
        rises[k]++;
        rise_cyc[k] = cyc;
      end
      rd_prev[k] = rdq[k];
      if (run && !(cyc >= g_lo && cyc <= g_hi))
        cmp((k == 0) ? "live_none" : "live_even",
            32'({dq[k], rdq[k], feq[k], peq[k]}),
            32'({m_data[k], m_rd[k], m_fe[k], m_pe[k]}));
    end
  end

  initial begin
    rst_n   = 1'b0;
    rx_line = 1'b1;
    sel     = 0;
    model_reset();
    wait_clk(4);
    cmp("rst_data", 32'(dq[0]), 32'(8'h00));
    cmp("rst_rdsig", 32'(rdq[0]), 32'(1'b0));
    cmp("rst_fe", 32'(feq[0]), 32'(1'b0));
    cmp("rst_pe_even", 32'(peq[1]), 32'(1'b0));
    rst_n = 1'b1;
    run = 1'b1;
    idle(BIT);

    // Single byte and its latency
    send_frame(0, 8'h50, 1'b0, 1'b1, 1'b0);
    cmp("byte_50", 32'(dq[0]), 32'(8'h50));
    cmp("byte_50_fe", 32'(feq[0]), 32'(1'b0));
    checks++;
    if (rise_cyc[0] - t_start < LAT_LO || rise_cyc[0] - t_start > LAT_HI) begin
      errors++;
      $display("FAIL latency actual=%0d required=%0d..%0d", rise_cyc[0] - t_start, LAT_LO, LAT_HI);
    end
    idle(BIT);

    // 13 bytes with zero idle gap
    for (int i = 0; i < 13; i++) begin
      send_frame(0, msg[i], 1'b0, 1'b1, 1'b0);
      cmp("b2b_byte", 32'(dq[0]), 32'(msg[i]));
    end
    cmp("b2b_rises", 32'(rises[0]), 32'(14));
    idle(BIT);

    // Framing error keeps the previous byte
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle(2 * BIT);
    cmp("fe_set", 32'(feq[0]), 32'(1'b1));
    cmp("fe_data", 32'(dq[0]), 32'(8'h0A));
    cmp("fe_rises", 32'(rises[0]), 32'(14));

    // 3-tick glitch on the idle line
    rx_line = 1'b0;
    g_lo = cyc;
    g_hi = cyc + G;
    wait_clk(30);
    idle(2 * BIT);
    cmp("glitch_data", 32'(dq[0]), 32'(8'h0A));
    cmp("glitch_fe", 32'(feq[0]), 32'(1'b1));
    cmp("glitch_rdsig", 32'(rdq[0]), 32'(1'b0));

    // Break: 20 bit times low yields a single frame error and no rearm
    rx_line = 1'b0;
    g_lo = cyc;
    g_hi = cyc + G;
    wait_clk(9 * BIT + HALF - G);
    g_lo = cyc;
    g_hi = cyc + 2 * G;
    wait_clk(G);
    m_fe[0] = 1'b1;
    wait_clk(G);
    wait_clk(20 * BIT - (9 * BIT + HALF + G));
    idle(2 * BIT);
    cmp("break_fe", 32'(feq[0]), 32'(1'b1));
    cmp("break_rises", 32'(rises[0]), 32'(14));

    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    cmp("clean_3c", 32'(dq[0]), 32'(8'h3C));
    cmp("clean_3c_fe", 32'(feq[0]), 32'(1'b0));
    cmp("clean_3c_rdsig", 32'(rdq[0]), 32'(1'b1));

    // Random bytes, random gaps, occasional bad stop bit
    for (int r = 0; r < 8; r++) begin
      logic [7:0] b;
      logic st;
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(0, b, 1'b0, st, 1'b0);
      idle(st ? int'($urandom_range(0, BIT)) : BIT + int'($urandom_range(0, BIT)));
    end
    cmp("rand_rises", 32'(rises[0]), 32'(m_rises[0]));

    // Reset during data bit 4 of 0x77
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0);
    idle(BIT);
    send_frame(0, 8'h77, 1'b0, 1'b1, 1'b1);
    cmp("rst_mid_data", 32'(dq[0]), 32'(8'h00));
    cmp("rst_mid_fe", 32'(feq[0]), 32'(1'b0));
    cmp("rst_mid_rdsig", 32'(rdq[0]), 32'(1'b0));
    cmp("rst_mid_rises", 32'(rises[0]), 32'(m_rises[0]));
    send_frame(0, 8'h77, 1'b0, 1'b1, 1'b0);
    cmp("after_rst_77", 32'(dq[0]), 32'(8'h77));
    idle(BIT);

    // Even parity receiver
    send_frame(1, 8'h0F, 1'b1, 1'b1, 1'b0);
    idle(BIT);
    cmp("par_bad_pe", 32'(peq[1]), 32'(1'b1));
    cmp("par_bad_rdsig", 32'(rdq[1]), 32'(1'b0));
    cmp("par_bad_data", 32'(dq[1]), 32'(8'h00));
    send_frame(1, 8'h0F, 1'b0, 1'b1, 1'b0);
    cmp("par_ok_data", 32'(dq[1]), 32'(8'h0F));
    cmp("par_ok_pe", 32'(peq[1]), 32'(1'b0));
    cmp("par_ok_rdsig", 32'(rdq[1]), 32'(1'b1));
    for (int r = 0; r < 2; r++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(1, b, ^b, 1'b1, 1'b0);
    end
    idle(BIT);
    cmp("rises_none", 32'(rises[0]), 32'(m_rises[0]));
    cmp("rises_even", 32'(rises[1]), 32'(m_rises[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
